volatility_buf_sched: RTL and testbench
=======================================

VOLATILITY_BUF_SCHED -- requirements
Module: volatility_buf_sched

Interface
REQ-001 SHALL have parameter NUM_STOCKS, default 4: number of per-stock circular buffers.
REQ-002 SHALL have parameter BUFFER_SIZE, default 20: entries per stock buffer.
REQ-003 SHALL have parameter DATA_W, default 32: price sample width.
REQ-004 SHALL have port i_clk  in  1  clock; all logic on posedge.
REQ-005 SHALL have port i_reset_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_price_valid  in  1  price sample offered.
REQ-007 SHALL have port i_price_stock  in  $clog2(NUM_STOCKS)  stock of offered sample.
REQ-008 SHALL have port i_price  in  DATA_W  sample value.
REQ-009 SHALL have port o_price_ready  out  1  sample accepted when valid&ready.
REQ-010 SHALL have port i_calc_req  in  1  request sweep of one stock buffer.
REQ-011 SHALL have port i_calc_stock  in  $clog2(NUM_STOCKS)  stock to sweep.
REQ-012 SHALL have port o_calc_busy  out  1  sweep in progress.
REQ-013 SHALL have port o_mem_addr  out  $clog2(NUM_STOCKS*BUFFER_SIZE)  single-port RAM address.
REQ-014 SHALL have port o_mem_we  out  1  RAM write enable.
REQ-015 SHALL have port o_mem_wdata  out  DATA_W  RAM write data.
REQ-016 SHALL have port i_mem_rdata  in  DATA_W  RAM read data, valid one cycle after read address.
REQ-017 SHALL have ports o_rd_data (DATA_W), o_rd_valid (1), o_rd_last (1)  out  sweep output stream.
REQ-018 SHALL have port o_calc_done  out  1  one-cycle pulse ending a sweep.
REQ-019 SHALL have port o_fill_count  out  $clog2(BUFFER_SIZE+1)  fill level of i_calc_stock.

Function
REQ-020 SHALL keep per stock a write pointer (0..BUFFER_SIZE-1) and fill count (0..BUFFER_SIZE).
REQ-021 SHALL write accepted sample at address stock*BUFFER_SIZE + wr_ptr in the acceptance cycle (o_mem_we=1, combinational address/data).
REQ-022 SHALL advance wr_ptr by 1, wrapping BUFFER_SIZE-1 -> 0; fill count saturates at BUFFER_SIZE (oldest overwritten).
REQ-023 SHALL implement FSM IDLE -> SWEEP -> DRAIN -> IDLE; o_calc_busy=1 outside IDLE.
REQ-024 SHALL accept i_calc_req only in IDLE; requests while busy ignored.
REQ-025 SHALL on accepted request snapshot N=fill count and start = (wr_ptr - N) mod BUFFER_SIZE.
REQ-026 SHALL with N=0 go IDLE -> DRAIN, no reads, o_calc_done next cycle, no o_rd_valid.
REQ-027 SHALL in SWEEP issue N reads oldest-to-newest, wrapping within the stock region.
REQ-028 SHALL assert o_rd_valid with i_mem_rdata one cycle after each read issue; o_rd_last on the N-th.
REQ-029 SHALL in DRAIN wait for final read data, pulse o_calc_done coincident with o_rd_last, return to IDLE.
REQ-030 SHALL arbitrate RAM per cycle: a write and a sweep read both pending -> alternate grant, write first after reset.
REQ-031 SHALL deassert o_price_ready when the read is granted, and whenever i_price_stock equals the stock being swept.
REQ-032 SHALL hold o_price_ready=1 in IDLE.
REQ-033 SHALL keep the sweep read address unchanged on a lost arbitration cycle.

Reset
REQ-034 SHALL on reset clear all wr_ptr and fill counts, FSM=IDLE, arbiter priority to write.
REQ-035 SHALL on reset drive o_mem_we=0, o_rd_valid=0, o_rd_last=0, o_calc_done=0, o_calc_busy=0.
REQ-036 SHALL on reset mid-sweep abort without o_calc_done.

Configuration
REQ-037 SHALL with VOL_SCHED_STATS_EN defined add output o_stall_cnt (32 bits), counting cycles with i_price_valid=1 and o_price_ready=0; saturating; cleared by reset.
REQ-038 SHALL without VOL_SCHED_STATS_EN omit o_stall_cnt and its counter entirely.

Structure
REQ-039 SHALL place FSM state enum and address/count width functions in shared package vol_pkg.
REQ-040 SHALL implement per-stock pointer/count storage as sub-module vol_ptr_file.

Verification
REQ-041 SHALL cover: 3 writes to stock 1 (10,20,30), then sweep stock 1 -> rd_data 10,20,30, last with 30, done same cycle.
REQ-042 SHALL cover: 25 writes (1..25) to stock 0, sweep -> fill 20, rd_data 6..25, addresses wrap 5..19,0..4.
REQ-043 SHALL cover: sweep empty stock 2 -> o_calc_done one cycle after request, no o_rd_valid.
REQ-044 SHALL cover: continuous stock-3 writes during stock-0 sweep of 4 entries -> grants alternate, ready 50%, sweep finishes in 8 issue cycles.
REQ-045 SHALL cover: write to stock 0 during stock-0 sweep -> ready=0 until done; reset mid-sweep -> busy=0, fill counts 0, no done.

Source files
------------

// File: rtl/vol_pkg.sv
// -----------------------------------------------------------------------------
// vol_pkg
// Shared definitions for the volatility buffer scheduler.
//   vol_state_e : sweep FSM states (IDLE -> SWEEP -> DRAIN -> IDLE)
//   idx_w(n)    : bits needed to index n items (minimum 1)
//   cnt_w(n)    : bits needed to hold a count of 0..n
// -----------------------------------------------------------------------------
package vol_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } vol_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/vol_ptr_file.sv
// -----------------------------------------------------------------------------
// vol_ptr_file
// Per-stock write pointer (0..BUFFER_SIZE-1) and fill count (0..BUFFER_SIZE).
// A write advances the stock's pointer with wrap and saturates its fill count,
// so once a buffer is full the oldest sample is the one being overwritten.
// Ports:
//   i_clk, i_reset_n : clock, synchronous active-low reset (clears all state)
//   i_wr_en          : a sample for i_wr_stock is written this cycle
//   i_wr_stock       : stock being written
//   o_wr_ptr         : current write pointer of i_wr_stock (combinational)
//   i_q_stock        : stock being queried by the sweep side
//   o_q_ptr, o_q_fill: write pointer and fill count of i_q_stock (combinational)
// -----------------------------------------------------------------------------
module vol_ptr_file
  import vol_pkg::*;
#(
  parameter int NUM_STOCKS  = 4,
  parameter int BUFFER_SIZE = 20,
  localparam int SW = idx_w(NUM_STOCKS),
  localparam int PW = idx_w(BUFFER_SIZE),
  localparam int CW = cnt_w(BUFFER_SIZE)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wr_en,
  input  logic [SW-1:0] i_wr_stock,
  output logic [PW-1:0] o_wr_ptr,
  input  logic [SW-1:0] i_q_stock,
  output logic [PW-1:0] o_q_ptr,
  output logic [CW-1:0] o_q_fill
);

  logic [PW-1:0] ptr_q  [NUM_STOCKS];
  logic [CW-1:0] fill_q [NUM_STOCKS];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        ptr_q[s]  <= '0;
        fill_q[s] <= '0;
      end
    end else if (i_wr_en) begin
      if (ptr_q[i_wr_stock] == PW'(BUFFER_SIZE - 1)) begin
        ptr_q[i_wr_stock] <= '0;
      end else begin
        ptr_q[i_wr_stock] <= ptr_q[i_wr_stock] + 1'b1;
      end
      if (fill_q[i_wr_stock] != CW'(BUFFER_SIZE)) begin
        fill_q[i_wr_stock] <= fill_q[i_wr_stock] + 1'b1;
      end
    end
  end

  assign o_wr_ptr = ptr_q[i_wr_stock];
  assign o_q_ptr  = ptr_q[i_q_stock];
  assign o_q_fill = fill_q[i_q_stock];

endmodule

// File: rtl/volatility_buf_sched.sv
// -----------------------------------------------------------------------------
// volatility_buf_sched
// Schedules a single-port RAM holding NUM_STOCKS circular price buffers of
// BUFFER_SIZE entries each. Incoming samples are written at
// stock*BUFFER_SIZE + wr_ptr; a calc request sweeps one stock's buffer from
// oldest to newest and streams the read data out.
//
// Handshakes:
//   price : a sample transfers on a rising edge where i_price_valid and
//           o_price_ready are both 1; the RAM write happens in that same cycle.
//           o_price_ready is 1 in IDLE, 0 on cycles the sweep read wins the
//           RAM and 0 while the offered stock is the one being swept.
//   calc  : i_calc_req is taken only when o_calc_busy is 0; requests while
//           busy are dropped. Output stream o_rd_valid/o_rd_data/o_rd_last has
//           no backpressure; o_calc_done pulses with o_rd_last (or alone, one
//           cycle after the request, for an empty buffer).
//
// Ports:
//   i_clk, i_reset_n             : clock, synchronous active-low reset
//   i_price_valid/stock, i_price : sample offer;  o_price_ready : accept
//   i_calc_req, i_calc_stock     : sweep request;  o_calc_busy  : FSM not IDLE
//   o_mem_addr/we/wdata          : RAM port;  i_mem_rdata : data one cycle
//                                  after a read address
//   o_rd_data/valid/last         : sweep output stream
//   o_calc_done                  : one-cycle end-of-sweep pulse
//   o_fill_count                 : fill level of i_calc_stock
//   o_dbg_state                  : FSM state (vol_state_e encoding)
//   o_stall_cnt                  : only with VOL_SCHED_STATS_EN defined;
//                                  saturating count of valid&!ready cycles
// -----------------------------------------------------------------------------
module volatility_buf_sched
  import vol_pkg::*;
#(
  parameter int NUM_STOCKS  = 4,
  parameter int BUFFER_SIZE = 20,
  parameter int DATA_W      = 32,
  localparam int SW = idx_w(NUM_STOCKS),
  localparam int PW = idx_w(BUFFER_SIZE),
  localparam int CW = cnt_w(BUFFER_SIZE),
  localparam int AW = idx_w(NUM_STOCKS * BUFFER_SIZE)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_price_valid,
  input  logic [SW-1:0]     i_price_stock,
  input  logic [DATA_W-1:0] i_price,
  output logic              o_price_ready,
  input  logic              i_calc_req,
  input  logic [SW-1:0]     i_calc_stock,
  output logic              o_calc_busy,
  output logic [AW-1:0]     o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_rd_last,
  output logic              o_calc_done,
  output logic [CW-1:0]     o_fill_count,
  output logic [1:0]        o_dbg_state
`ifdef VOL_SCHED_STATS_EN
  ,
  output logic [31:0]       o_stall_cnt
`endif
);

  vol_state_e    state_q, state_d;
  logic [SW-1:0] sweep_stock_q;
  logic [AW-1:0] sweep_base_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] left_q;      // reads still to be issued
  logic          prio_wr_q;   // 1: write wins the next contended cycle
  logic          rd_valid_q;
  logic          rd_last_q;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] q_ptr;
  logic [CW-1:0] q_fill;

  logic          busy;
  logic          blocked;
  logic          wr_pend;
  logic          rd_pend;
  logic          wr_gnt;
  logic          rd_gnt;
  logic          req_acc;
  int            start_i;
  logic [PW-1:0] start_ptr;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  vol_ptr_file #(
    .NUM_STOCKS  (NUM_STOCKS),
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_ptr_file (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_wr_en    (wr_gnt),
    .i_wr_stock (i_price_stock),
    .o_wr_ptr   (wr_ptr),
    .i_q_stock  (i_calc_stock),
    .o_q_ptr    (q_ptr),
    .o_q_fill   (q_fill)
  );

  // RAM arbitration. A write to the stock under sweep is held off entirely so
  // the sweep sees a stable buffer; other writes share the port with the sweep
  // reads, alternating on contended cycles.
  always_comb begin
    busy    = (state_q != ST_IDLE);
    blocked = busy && (i_price_stock == sweep_stock_q);
    wr_pend = i_reset_n && i_price_valid && !blocked;
    rd_pend = i_reset_n && (state_q == ST_SWEEP);
    rd_gnt  = rd_pend && !(wr_pend && prio_wr_q);
    wr_gnt  = wr_pend && !rd_gnt;
    req_acc = i_reset_n && (state_q == ST_IDLE) && i_calc_req;
  end

  // Oldest entry = (wr_ptr - fill) mod BUFFER_SIZE. A same-cycle write to the
  // requested stock is not part of the snapshot.
  always_comb begin
    start_i = int'(q_ptr) - int'(q_fill);
    if (start_i < 0) begin
      start_i = start_i + BUFFER_SIZE;
    end
    start_ptr = PW'(start_i);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_acc) begin
          state_d = (q_fill == '0) ? ST_DRAIN : ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (rd_gnt && (left_q == CW'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sweep_stock_q <= '0;
      sweep_base_q  <= '0;
      rd_ptr_q      <= '0;
      left_q        <= '0;
      prio_wr_q     <= 1'b1;
      rd_valid_q    <= 1'b0;
      rd_last_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_gnt;
      rd_last_q  <= rd_gnt && (left_q == CW'(1));
      if (rd_pend && wr_pend) begin
        prio_wr_q <= !prio_wr_q;
      end
      if (req_acc) begin
        sweep_stock_q <= i_calc_stock;
        sweep_base_q  <= AW'(int'(i_calc_stock) * BUFFER_SIZE);
        rd_ptr_q      <= start_ptr;
        left_q        <= q_fill;
      end else if (rd_gnt) begin
        // A lost arbitration cycle leaves rd_ptr_q untouched, so the same
        // address is re-presented next cycle.
        if (rd_ptr_q == PW'(BUFFER_SIZE - 1)) begin
          rd_ptr_q <= '0;
        end else begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        left_q <= left_q - 1'b1;
      end
    end
  end

  assign wr_addr = AW'(int'(i_price_stock) * BUFFER_SIZE + int'(wr_ptr));
  assign rd_addr = sweep_base_q + AW'(rd_ptr_q);

  assign o_price_ready = i_reset_n && !blocked && !rd_gnt;
  assign o_calc_busy   = i_reset_n && busy;
  assign o_mem_we      = wr_gnt;
  assign o_mem_addr    = wr_gnt ? wr_addr : rd_addr;
  assign o_mem_wdata   = i_price;
  assign o_rd_data     = i_mem_rdata;
  assign o_rd_valid    = i_reset_n && rd_valid_q;
  assign o_rd_last     = i_reset_n && rd_last_q;
  assign o_calc_done   = i_reset_n && (state_q == ST_DRAIN);
  assign o_fill_count  = q_fill;
  assign o_dbg_state   = state_q;

`ifdef VOL_SCHED_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      stall_q <= '0;
    end else if (i_price_valid && !o_price_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_volatility_buf_sched.sv
// -----------------------------------------------------------------------------
// tb_volatility_buf_sched
// Directed bench for volatility_buf_sched with a behavioural single-port RAM.
// Stimulus pushes expected writes, read addresses and read data into queues;
// a monitor pops and compares whenever the DUT writes, issues a sweep read or
// presents o_rd_valid.
// -----------------------------------------------------------------------------
module tb_volatility_buf_sched;

  localparam int NS = 4;
  localparam int BS = 20;
  localparam int DW = 32;
  localparam int AW = 7;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_price_valid;
  logic [1:0]    i_price_stock;
  logic [DW-1:0] i_price;
  logic          o_price_ready;
  logic          i_calc_req;
  logic [1:0]    i_calc_stock;
  logic          o_calc_busy;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_we;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid;
  logic          o_rd_last;
  logic          o_calc_done;
  logic [4:0]    o_fill_count;
  logic [1:0]    o_dbg_state;
`ifdef VOL_SCHED_STATS_EN
  logic [31:0]   o_stall_cnt;
`endif

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  volatility_buf_sched #(
    .NUM_STOCKS  (NS),
    .BUFFER_SIZE (BS),
    .DATA_W      (DW)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_price_valid (i_price_valid),
    .i_price_stock (i_price_stock),
    .i_price       (i_price),
    .o_price_ready (o_price_ready),
    .i_calc_req    (i_calc_req),
    .i_calc_stock  (i_calc_stock),
    .o_calc_busy   (o_calc_busy),
    .o_mem_addr    (o_mem_addr),
    .o_mem_we      (o_mem_we),
    .o_mem_wdata   (o_mem_wdata),
    .i_mem_rdata   (i_mem_rdata),
    .o_rd_data     (o_rd_data),
    .o_rd_valid    (o_rd_valid),
    .o_rd_last     (o_rd_last),
    .o_calc_done   (o_calc_done),
    .o_fill_count  (o_fill_count),
    .o_dbg_state   (o_dbg_state)
`ifdef VOL_SCHED_STATS_EN
    ,
    .o_stall_cnt   (o_stall_cnt)
`endif
  );

  // Single-port RAM: write on we, registered read data.
  logic [DW-1:0] mem [128];
  always @(posedge i_clk) begin
    if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    i_mem_rdata <= mem[o_mem_addr];
  end

  // ---------------- scoreboard ----------------
  logic [DW:0]      exp_q[$];       // {last, data}
  logic [AW-1:0]    exp_addr_q[$];  // sweep read addresses
  logic [AW+DW-1:0] exp_wr_q[$];    // {addr, data} of RAM writes
  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;
  int wp[NS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: samples 2 time units after the falling edge, after the stimulus
  // process has pushed any expectation for the current cycle.
  initial begin
    logic [DW:0]      e;
    logic [AW+DW-1:0] w;
    forever begin
      @(negedge i_clk);
      #2;
      if (o_mem_we) begin
        if (exp_wr_q.size() == 0) begin
          flag("unexpected_write", "write with no expected write queued");
        end else begin
          w = exp_wr_q.pop_front();
          chk("wr_addr", 64'(o_mem_addr), 64'(w[AW+DW-1:DW]));
          chk("wr_data", 64'(o_mem_wdata), 64'(w[DW-1:0]));
        end
      end else if (o_calc_busy && o_dbg_state == 2'd1) begin
        if (exp_addr_q.size() == 0) begin
          flag("unexpected_read", "read issue with no expected address queued");
        end else begin
          chk("rd_addr", 64'(o_mem_addr), 64'(exp_addr_q.pop_front()));
        end
      end
      if (o_rd_valid) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_rd_valid", "o_rd_valid with no expected data queued");
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", 64'(o_rd_data), 64'(e[DW-1:0]));
          chk("rd_last", 64'(o_rd_last), 64'(e[DW]));
          if (e[DW]) chk("done_with_last", 64'(o_calc_done), 64'd1);
        end
      end
      if (o_calc_done) done_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_sample(input int stock, input logic [DW-1:0] val);
    int t;
    i_price_valid = 1'b1;
    i_price_stock = 2'(stock);
    i_price       = val;
    for (t = 0; t < 50; t++) begin
      @(negedge i_clk);
      if (o_price_ready) break;
    end
    if (t == 50) begin
      flag("write_timeout", "o_price_ready never rose");
    end else begin
      exp_wr_q.push_back({AW'(stock * BS + wp[stock]), val});
      wp[stock] = (wp[stock] + 1) % BS;
    end
    @(posedge i_clk);
    #1;
    i_price_valid = 1'b0;
  endtask

  // Returns the number of falling edges after the request was driven at
  // which o_calc_done was seen (N+1 for an uncontended sweep of N entries).
  task automatic do_sweep(input int stock, output int cycles);
    i_calc_req   = 1'b1;
    i_calc_stock = 2'(stock);
    cycles = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge i_clk);
      if (o_calc_done) begin
        cycles = t;
        break;
      end
      @(posedge i_clk);
      #1;
      i_calc_req = 1'b0;
    end
    i_calc_req = 1'b0;
    if (cycles < 0) flag("sweep_timeout", "o_calc_done never pulsed");
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_full_stock0();
    // Stock 0 after samples 1..25: slots 0..4 hold 21..25, slots 5..19 hold
    // 6..20, wr_ptr = 5, so the sweep starts at slot 5.
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back({(k == 19), DW'(6 + k)});
      exp_addr_q.push_back(AW'((5 + k) % 20));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int d0;
    int fin;
    int leak;
    int busy_cyc;
    int sweep_cyc;
    int rdy_cnt;
    logic acc;
    logic we_seq[8];

    for (int s = 0; s < NS; s++) wp[s] = 0;
    i_reset_n     = 1'b0;
    i_price_valid = 1'b0;
    i_price_stock = '0;
    i_price       = '0;
    i_calc_req    = 1'b0;
    i_calc_stock  = '0;

    // Reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_busy", 64'(o_calc_busy), 64'd0);
    chk("rst_we", 64'(o_mem_we), 64'd0);
    chk("rst_rd_valid", 64'(o_rd_valid), 64'd0);
    chk("rst_rd_last", 64'(o_rd_last), 64'd0);
    chk("rst_done", 64'(o_calc_done), 64'd0);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    @(negedge i_clk);
    chk("idle_ready", 64'(o_price_ready), 64'd1);
    chk("idle_state", 64'(o_dbg_state), 64'd0);
    chk("idle_fill", 64'(o_fill_count), 64'd0);
    @(posedge i_clk);
    #1;

    // Three samples into stock 1, sweep returns them oldest first
    write_sample(1, 10);
    write_sample(1, 20);
    write_sample(1, 30);
    i_calc_stock = 2'd1;
    #1;
    chk("fill_s1", 64'(o_fill_count), 64'd3);
    exp_q.push_back({1'b0, DW'(10)});
    exp_q.push_back({1'b0, DW'(20)});
    exp_q.push_back({1'b1, DW'(30)});
    exp_addr_q.push_back(AW'(20));
    exp_addr_q.push_back(AW'(21));
    exp_addr_q.push_back(AW'(22));
    d0 = done_seen;
    do_sweep(1, cyc);
    chk("s1_done_cycle", 64'(cyc), 64'd4);
    chk("s1_done_count", 64'(done_seen), 64'(d0 + 1));

    // 25 samples into stock 0: buffer wraps, oldest five overwritten
    for (int k = 1; k <= 25; k++) write_sample(0, DW'(k));
    i_calc_stock = 2'd0;
    #1;
    chk("fill_s0_sat", 64'(o_fill_count), 64'd20);
    push_full_stock0();
    d0 = done_seen;
    do_sweep(0, cyc);
    chk("s0_done_cycle", 64'(cyc), 64'd21);
    chk("s0_done_count", 64'(done_seen), 64'(d0 + 1));

    // Empty stock 2: done one cycle after the request, no data
    d0 = done_seen;
    do_sweep(2, cyc);
    chk("empty_done_cycle", 64'(cyc), 64'd1);
    chk("empty_done_count", 64'(done_seen), 64'(d0 + 1));
    chk("empty_no_data", 64'(exp_q.size()), 64'd0);

    // Write to the stock being swept is held off until the sweep ends
    push_full_stock0();
    d0 = done_seen;
    i_calc_req   = 1'b1;
    i_calc_stock = 2'd0;
    @(posedge i_clk);
    #1;
    i_calc_req    = 1'b0;
    i_price_valid = 1'b1;
    i_price_stock = 2'd0;
    i_price       = 77;
    fin = 0;
    leak = 0;
    busy_cyc = 0;
    for (int t = 0; t < 60 && fin == 0; t++) begin
      @(negedge i_clk);
      if (o_calc_busy) begin
        busy_cyc++;
        if (o_price_ready) leak++;
      end
      if (o_calc_done) fin = 1;
      @(posedge i_clk);
      #1;
    end
    i_price_valid = 1'b0;
    chk("blk_finished", 64'(fin), 64'd1);
    chk("blk_ready_leak", 64'(leak), 64'd0);
    chk("blk_busy_cycles", 64'(busy_cyc), 64'd21);
    chk("blk_done_count", 64'(done_seen), 64'(d0 + 1));
    @(negedge i_clk);
    chk("blk_ready_after", 64'(o_price_ready), 64'd1);
    chk("blk_busy_after", 64'(o_calc_busy), 64'd0);
    @(posedge i_clk);
    #1;

    // Reset in the middle of a sweep: abort, no done, pointers cleared
    push_full_stock0();
    d0 = done_seen;
    i_calc_req   = 1'b1;
    i_calc_stock = 2'd0;
    @(posedge i_clk);
    #1;
    i_calc_req = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    i_reset_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    for (int s = 0; s < NS; s++) wp[s] = 0;
    @(negedge i_clk);
    chk("mid_rst_busy", 64'(o_calc_busy), 64'd0);
    chk("mid_rst_state", 64'(o_dbg_state), 64'd0);
    chk("mid_rst_rd_valid", 64'(o_rd_valid), 64'd0);
    chk("mid_rst_done", 64'(o_calc_done), 64'd0);
    chk("mid_rst_ready", 64'(o_price_ready), 64'd1);
    for (int s = 0; s < NS; s++) begin
      i_calc_stock = 2'(s);
      #1;
      chk("mid_rst_fill", 64'(o_fill_count), 64'd0);
    end
    @(posedge i_clk);
    #1;
    chk("mid_rst_no_done", 64'(done_seen), 64'(d0));

    // Continuous stock-3 writes against a 4-entry stock-0 sweep
    for (int k = 0; k < 4; k++) write_sample(0, DW'(100 + k));
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({(k == 3), DW'(100 + k)});
      exp_addr_q.push_back(AW'(k));
    end
    d0 = done_seen;
    i_price_valid = 1'b1;
    i_price_stock = 2'd3;
    i_price       = 200;
    i_calc_req    = 1'b1;
    i_calc_stock  = 2'd0;
    fin = 0;
    sweep_cyc = 0;
    rdy_cnt = 0;
    for (int i = 0; i < 8; i++) we_seq[i] = 1'b0;
    for (int t = 0; t < 40 && fin == 0; t++) begin
      @(negedge i_clk);
      acc = o_price_ready;
      if (acc) begin
        exp_wr_q.push_back({AW'(3 * BS + wp[3]), i_price});
        wp[3] = (wp[3] + 1) % BS;
      end
      if (o_dbg_state == 2'd1) begin
        if (sweep_cyc < 8) we_seq[sweep_cyc] = o_mem_we;
        sweep_cyc++;
        if (acc) rdy_cnt++;
      end
      if (o_calc_done) fin = 1;
      @(posedge i_clk);
      #1;
      i_calc_req = 1'b0;
      if (acc) i_price = i_price + 1;
    end
    i_price_valid = 1'b0;
    chk("arb_finished", 64'(fin), 64'd1);
    chk("arb_sweep_cycles", 64'(sweep_cyc), 64'd8);
    chk("arb_ready_cycles", 64'(rdy_cnt), 64'd4);
    for (int i = 0; i < 8; i++) begin
      chk("arb_grant_alt", 64'(we_seq[i]), (i % 2 == 0) ? 64'd1 : 64'd0);
    end
    chk("arb_done_count", 64'(done_seen), 64'(d0 + 1));

    // Everything expected has been consumed
    repeat (3) @(posedge i_clk);
    #1;
    chk("left_rd_data", 64'(exp_q.size()), 64'd0);
    chk("left_rd_addr", 64'(exp_addr_q.size()), 64'd0);
    chk("left_writes", 64'(exp_wr_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
